uart_pkt_rx: RTL

Framing stage directly downstream of the UART byte receiver. It consumes the rx_valid/rx_data byte pulses and hunts for a sync byte. It then parses a length-prefixed packet and streams the payload bytes through an internal FIFO to the encoder-side consumer over a valid/ready interface with a last marker. It also reports per-frame completion status, inter-byte timeout, and overflow.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_fifo.sv | 55 +++++
 rtl/uart_pkt_rx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet framing path: sync byte value,
// parser state encoding and frame completion cause codes.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LEN  = 2'd1,
        PAY  = 2'd2,
        CK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_OVF     = 2'd2,
        ERR_FRAME   = 2'd3
    } err_cause_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO carrying {last, data} words. The head word is read
// combinationally so a word pushed into an empty FIFO is visible on the
// cycle right after the push. A push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_pkt_rx.sv
// UART packet framer: hunts for the sync byte, parses a length-prefixed
// frame, streams payload bytes through a FIFO with a last marker and
// reports per-frame status, inter-byte timeout and sticky overflow.
// Optional trailing checksum byte: define UART_PKT_CKSUM_EN.
module uart_pkt_rx
    import uart_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_TICKS = 320
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx_tick,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    output logic       pkt_last,
    input  logic       pkt_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_cause,
    output logic       overflow
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

    state_t     state_reg,  state_next;
    logic [7:0] len_reg,    len_next;
    logic [7:0] cnt_reg,    cnt_next;
    err_cause_t err_reg,    err_next;
    err_cause_t cause_reg,  cause_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic       done_reg,   done_next;
    logic       ovf_reg,    ovf_next;
`ifdef UART_PKT_CKSUM_EN
    logic [7:0] ck_reg,     ck_next;
`endif

    logic       fifo_push;
    logic [8:0] fifo_push_data;
    logic       fifo_pop;
    logic [8:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       is_last;

    uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head word is masked while empty so outputs read 0 out of reset.
    assign pkt_valid  = ~fifo_empty;
    assign pkt_data   = pkt_valid ? fifo_head[7:0] : 8'h00;
    assign pkt_last   = pkt_valid & fifo_head[8];
    assign fifo_pop   = pkt_valid & pkt_ready;
    assign frame_done = done_reg;
    assign err_cause  = cause_reg;
    assign frame_err  = (cause_reg != ERR_NONE);
    assign overflow   = ovf_reg;
    assign is_last    = (cnt_reg == (len_reg - 8'd1));

    // Parser state and frame bookkeeping registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= HUNT;
            len_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= ERR_NONE;
            cause_reg <= ERR_NONE;
            tmo_reg   <= '0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
`ifdef UART_PKT_CKSUM_EN
            ck_reg    <= '0;
`endif
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            cause_reg <= cause_next;
            tmo_reg   <= tmo_next;
            done_reg  <= done_next;
            ovf_reg   <= ovf_next;
`ifdef UART_PKT_CKSUM_EN
            ck_reg    <= ck_next;
`endif
        end
    end

    // Next-state logic: byte-driven parsing, then the inter-byte timeout,
    // which only acts in cycles without a byte so a byte beats the tick.
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        err_next       = err_reg;
        cause_next     = cause_reg;
        tmo_next       = tmo_reg;
        done_next      = 1'b0;
        ovf_next       = ovf_reg;
        fifo_push      = 1'b0;
        fifo_push_data = '0;
`ifdef UART_PKT_CKSUM_EN
        ck_next        = ck_reg;
`endif

        case (state_reg)
            HUNT: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'h00) begin
                        done_next  = 1'b1;
                        cause_next = ERR_FRAME;
                        state_next = HUNT;
                    end else begin
                        len_next   = rx_data;
                        cnt_next   = '0;
                        err_next   = ERR_NONE;
                        state_next = PAY;
`ifdef UART_PKT_CKSUM_EN
                        ck_next    = rx_data;
`endif
                    end
                end
            end
            PAY: begin
                if (rx_valid) begin
                    fifo_push      = 1'b1;
                    fifo_push_data = {is_last, rx_data};
                    // Dropped byte: the FIFO cannot take it this cycle.
                    if (fifo_full && !fifo_pop) begin
                        ovf_next = 1'b1;
                        if (err_reg == ERR_NONE) begin
                            err_next = ERR_OVF;
                        end
                    end
                    cnt_next = cnt_reg + 8'd1;
`ifdef UART_PKT_CKSUM_EN
                    ck_next  = ck_reg ^ rx_data;
`endif
                    if (is_last) begin
`ifdef UART_PKT_CKSUM_EN
                        state_next = CK;
`else
                        state_next = HUNT;
                        done_next  = 1'b1;
                        cause_next = err_next;
`endif
                    end
                end
            end
            CK: begin
`ifdef UART_PKT_CKSUM_EN
                if (rx_valid) begin
                    done_next  = 1'b1;
                    state_next = HUNT;
                    if (err_reg != ERR_NONE) begin
                        cause_next = err_reg;
                    end else if (rx_data != ck_reg) begin
                        cause_next = ERR_FRAME;
                    end else begin
                        cause_next = ERR_NONE;
                    end
                end
`else
                state_next = HUNT;
`endif
            end
            default: begin
                state_next = HUNT;
            end
        endcase

        if ((state_reg == HUNT) || rx_valid) begin
            tmo_next = '0;
        end else if (rx_tick) begin
            if (tmo_reg == TMO_LAST) begin
                tmo_next   = '0;
                state_next = HUNT;
                done_next  = 1'b1;
                cause_next = ERR_TIMEOUT;
            end else begin
                tmo_next = tmo_reg + 1'b1;
            end
        end
    end

endmodule
